lcd1602_drive: RTL and testbench
================================

# lcd1602_drive

HD44780-compatible driver for the DE2 LCD1602 module. It takes the 32-character frame from the display data-conversion stage, formatted as a 256-bit `data_in` word. After power-on it runs the controller initialisation sequence, then rewrites both display lines continuously over the 8-bit parallel bus. It also forwards the backlight request to the panel.

## Interface
- `TICK_DIV`, 50000: clock cycles per bus tick (1 ms at 50 MHz); benches override to a small value.
- `PWR_TICKS`, 20: ticks of power-on wait before the first command.

- `CLOCK_50`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  256  frame word; char k = `data_in[8k+7:8k]`, k=0..15 line 1 cols 0..15, k=16..31 line 2 cols 0..15.
- `bl_in`  in  1  backlight request.
- `LCD_DATA`  out  8  bus data/command byte.
- `LCD_RS`  out  1  0 = command, 1 = data.
- `LCD_RW`  out  1  tied 0 (write only).
- `LCD_EN`  out  1  enable strobe; controller latches on falling edge.
- `LCD_ON`  out  1  panel power.
- `LCD_BLON`  out  1  backlight enable.
- `frame_done`  out  1  one-cycle pulse per completed 32-character frame.

## Operation
- The design has one clock, `CLOCK_50`. Reset is asynchronous and active-low via `rst_n`. All outputs are registered.
- Reset values: `LCD_DATA`=0x00, `LCD_RS`=0, `LCD_RW`=0, `LCD_EN`=0, `LCD_ON`=0, `LCD_BLON`=0, `frame_done`=0. Internal counters and state are cleared to WAIT_PWR / divider 0.
- `LCD_ON` goes to 1 on the first clock edge after reset release and stays at 1.
- `LCD_BLON` is `bl_in` registered by one clock. It is independent of the state machine.
- Tick: a divider counts 0..TICK_DIV-1. The tick fires on the edge where the divider equals TICK_DIV-1, and the divider then returns to 0. All state and bus changes happen only on tick edges.
- Every bus write takes 3 ticks:
  - SETUP: `LCD_RS` and `LCD_DATA` are driven; `LCD_EN`=0.
  - PULSE: `LCD_EN`=1.
  - HOLD: `LCD_EN`=0; `LCD_RS` and `LCD_DATA` are held.
  - The next write's SETUP follows on the next tick.
- State machine:
  - WAIT_PWR: count PWR_TICKS ticks. The PWR_TICKS-th tick enters INIT, write 0.
  - INIT: six commands, RS=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. After the sixth HOLD, go to L1_ADDR.
  - L1_ADDR: command 0x80. Entering SETUP copies `data_in` into a 256-bit shadow register.
  - L1_CHAR: 16 data writes, RS=1, shadow chars 0..15 in order.
  - L2_ADDR: command 0xC0.
  - L2_CHAR: 16 data writes, RS=1, shadow chars 16..31.
  - After char 31 HOLD, go back to L1_ADDR. Initialisation is never repeated except after reset.
- `frame_done` is high for exactly the clock edge that leaves char 31 HOLD, which is the same edge that takes the new snapshot.
- Character bytes are forwarded unchanged, with no filtering of non-printable codes.

## Timing
- One write takes 3·TICK_DIV cycles. `LCD_EN` is high for exactly TICK_DIV cycles. RS and DATA are stable for TICK_DIV cycles before the EN rise and for TICK_DIV cycles after the EN fall.
- At default parameters, EN high is 1 ms, which exceeds the 0x01 clear execution time of 1.52 ms only when combined with HOLD plus the next SETUP (2 ms). No extra clear delay is needed.
- A frame is 34 writes, or 102·TICK_DIV cycles: 102 ms at defaults, about 9.8 Hz refresh.
- The first tick after reset release is at edge TICK_DIV. The first SETUP is at tick PWR_TICKS and the first EN rise at tick PWR_TICKS+1.
- `data_in` changes during a frame have no effect until the next L1_ADDR snapshot, so every frame is coherent.
- Reset asserted at any point, including mid-PULSE: all outputs go to reset values immediately, without waiting for a clock. After release the full WAIT_PWR and INIT sequence runs again.
- `bl_in` toggling at any time has no effect on `LCD_EN`, `LCD_RS`, `LCD_DATA` or the state sequence.

## Test plan
All scenarios use TICK_DIV=4 and PWR_TICKS=2.
- **Reset/init:** release `rst_n` -> `LCD_EN` first rises at edge 12 and stays high 4 cycles, with RS=0 and DATA=0x38. Bytes captured at EN falls are 38,38,38,0C,01,06, all with RS=0. `LCD_RW`=0 throughout.
- **Frame content:** line 1 = "2024/05/17 12:30", line 2 = "Friday" plus 10 spaces -> EN-fall capture is 0x80 (RS=0), then the 16 line-1 ASCII bytes (RS=1), then 0xC0 (RS=0), then 46,72,69,64,61,79 and ten 0x20 (RS=1).
- **Snapshot coherence:** change `data_in` from all 0x41 to all 0x42 after the 5th line-1 character's EN fall -> the rest of that frame is 0x41. The next frame is all 0x42, with the change taking effect at the snapshot coinciding with `frame_done`.
- **Reset mid-pulse:** assert `rst_n`=0 while `LCD_EN`=1 -> `LCD_EN`, `LCD_DATA`, `LCD_RS` and `LCD_ON` are all 0 before the next clock edge. After release the first EN rise is again at edge 12, with 0x38.
- **Backlight:** toggle `bl_in` 0→1→0 mid-frame -> `LCD_BLON` follows with a 1-cycle lag. The EN/DATA capture is identical to a run without the toggle.
- **Frame period:** successive `frame_done` pulses are exactly 408 cycles apart and each is 1 cycle wide.

Source files
------------

// File: rtl/lcd1602_drive.sv
// HD44780 driver for the DE2 LCD1602 panel: runs the power-on init sequence, then
// rewrites both display lines from a per-frame snapshot of data_in, forever.
module lcd1602_drive #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned PWR_TICKS = 20
) (
    input  logic         CLOCK_50,
    input  logic         rst_n,
    input  logic [255:0] data_in,
    input  logic         bl_in,
    output logic [7:0]   LCD_DATA,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic         LCD_ON,
    output logic         LCD_BLON,
    output logic         frame_done
);
    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PwrW = (PWR_TICKS > 1) ? $clog2(PWR_TICKS) : 1;

    typedef enum logic [2:0] {
        StWaitPwr, StInit, StL1Addr, StL1Char, StL2Addr, StL2Char
    } state_e;
    typedef enum logic [1:0] {PhSetup, PhPulse, PhHold} phase_e;

    state_e          state_q;
    phase_e          phase_q;
    logic [DivW-1:0] div_q;
    logic [PwrW-1:0] pwr_q;
    logic [4:0]      idx_q;
    logic [255:0]    shadow_q;

    logic            tick;
    logic [4:0]      idx_nxt;
    logic [7:0]      char_nxt;
    logic [7:0]      init_nxt;

    assign tick     = (div_q == DivW'(TICK_DIV - 1));
    assign idx_nxt  = idx_q + 5'd1;
    assign char_nxt = shadow_q[{idx_nxt, 3'b000} +: 8];

    always_comb begin
        init_nxt = 8'h06;
        case (idx_nxt)
            5'd1, 5'd2: init_nxt = 8'h38;
            5'd3:       init_nxt = 8'h0C;
            5'd4:       init_nxt = 8'h01;
            default:    init_nxt = 8'h06;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StWaitPwr;
            phase_q    <= PhSetup;
            div_q      <= '0;
            pwr_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            LCD_DATA   <= 8'h00;
            LCD_RS     <= 1'b0;
            LCD_RW     <= 1'b0;
            LCD_EN     <= 1'b0;
            LCD_ON     <= 1'b0;
            LCD_BLON   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            LCD_ON     <= 1'b1;
            LCD_RW     <= 1'b0;
            LCD_BLON   <= bl_in;
            frame_done <= 1'b0;
            div_q      <= tick ? '0 : div_q + DivW'(1);
            if (tick) begin
                if (state_q == StWaitPwr) begin
                    if (pwr_q == PwrW'(PWR_TICKS - 1)) begin
                        state_q  <= StInit;
                        phase_q  <= PhSetup;
                        idx_q    <= '0;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= 8'h38;
                    end else begin
                        pwr_q <= pwr_q + PwrW'(1);
                    end
                end else begin
                    unique case (phase_q)
                        PhSetup: begin
                            phase_q <= PhPulse;
                            LCD_EN  <= 1'b1;
                        end
                        PhPulse: begin
                            phase_q <= PhHold;
                            LCD_EN  <= 1'b0;
                        end
                        default: begin
                            phase_q <= PhSetup;
                            // idx_q parks at 31 in L1_ADDR so that idx_nxt wraps to char 0
                            case (state_q)
                                StInit: begin
                                    LCD_RS <= 1'b0;
                                    if (idx_q == 5'd5) begin
                                        state_q  <= StL1Addr;
                                        idx_q    <= 5'd31;
                                        LCD_DATA <= 8'h80;
                                        shadow_q <= data_in;
                                    end else begin
                                        idx_q    <= idx_nxt;
                                        LCD_DATA <= init_nxt;
                                    end
                                end
                                StL1Addr: begin
                                    state_q  <= StL1Char;
                                    idx_q    <= idx_nxt;
                                    LCD_RS   <= 1'b1;
                                    LCD_DATA <= char_nxt;
                                end
                                StL1Char: begin
                                    if (idx_q == 5'd15) begin
                                        state_q  <= StL2Addr;
                                        LCD_RS   <= 1'b0;
                                        LCD_DATA <= 8'hC0;
                                    end else begin
                                        idx_q    <= idx_nxt;
                                        LCD_DATA <= char_nxt;
                                    end
                                end
                                StL2Addr: begin
                                    state_q  <= StL2Char;
                                    idx_q    <= idx_nxt;
                                    LCD_RS   <= 1'b1;
                                    LCD_DATA <= char_nxt;
                                end
                                StL2Char: begin
                                    if (idx_q == 5'd31) begin
                                        state_q    <= StL1Addr;
                                        LCD_RS     <= 1'b0;
                                        LCD_DATA   <= 8'h80;
                                        shadow_q   <= data_in;
                                        frame_done <= 1'b1;
                                    end else begin
                                        idx_q    <= idx_nxt;
                                        LCD_DATA <= char_nxt;
                                    end
                                end
                                default: begin
                                    state_q <= StWaitPwr;
                                    pwr_q   <= '0;
                                end
                            endcase
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd1602_drive.sv
// Bench for lcd1602_drive: a tick/write-count model predicts every output each cycle,
// plus literal checks of init bytes, frame content, snapshot coherence and reset.
module tb_lcd1602_drive;
    localparam int TD  = 4;
    localparam int PWR = 2;

    logic         CLOCK_50 = 1'b0;
    logic         rst_n;
    logic [255:0] data_in;
    logic         bl_in;
    logic [7:0]   LCD_DATA;
    logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, frame_done;

    lcd1602_drive #(.TICK_DIV(TD), .PWR_TICKS(PWR)) dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .bl_in     (bl_in),
        .LCD_DATA  (LCD_DATA),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_ON    (LCD_ON),
        .LCD_BLON  (LCD_BLON),
        .frame_done(frame_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int           n_cmp = 0;
    int           n_err = 0;
    int           edge_cnt;
    logic         exp_blon;
    logic [255:0] snaps [64];
    logic [8:0]   caps [$];
    int           fd_edges [$];
    int           rise_edge;
    logic [7:0]   rise_data;
    logic         en_prev;
    logic [7:0]   init_tab [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] build(input string l1, input string l2);
        logic [255:0] v = '0;
        for (int i = 0; i < 16; i++) begin
            v[8*i +: 8]      = l1[i];
            v[8*(16+i) +: 8] = l2[i];
        end
        return v;
    endfunction

    // Frame f starts (L1 address write SETUP + snapshot) at tick PWR + 18 + 102*f.
    function automatic bit is_frame_start(input int e);
        int t = e / TD;
        return (e % TD == 0) && (t >= PWR + 18) && ((t - PWR - 18) % 102 == 0);
    endfunction

    function automatic logic [13:0] model_out(input int e, input logic blon);
        int t, w, ph, f, pos;
        logic en, rs, on, fd;
        logic [7:0] d;
        logic [255:0] s;
        en = 1'b0; rs = 1'b0; d = 8'h00; fd = 1'b0;
        on = (e >= 1);
        t  = e / TD;
        if (t >= PWR) begin
            w  = (t - PWR) / 3;
            ph = (t - PWR) % 3;
            en = (ph == 1);
            if (w < 6) begin
                d = init_tab[w];
            end else begin
                f   = (w - 6) / 34;
                pos = (w - 6) % 34;
                s   = snaps[f % 64];
                if (pos == 0) d = 8'h80;
                else if (pos <= 16) begin rs = 1'b1; d = s[8*(pos-1) +: 8]; end
                else if (pos == 17) d = 8'hC0;
                else begin rs = 1'b1; d = s[8*(pos-2) +: 8]; end
            end
            fd = is_frame_start(e) && (t >= PWR + 18 + 102);
        end
        return {en, rs, 1'b0, on, blon, fd, d};
    endfunction

    initial begin
        int e;
        logic b;
        edge_cnt = 0; exp_blon = 1'b0; en_prev = 1'b0; rise_edge = -1; rise_data = '0;
        forever begin
            @(posedge CLOCK_50);
            if (!rst_n) begin
                edge_cnt = 0; exp_blon = 1'b0; en_prev = 1'b0; rise_edge = -1;
                caps.delete();
                fd_edges.delete();
            end else begin
                edge_cnt++;
                exp_blon = bl_in;
                if (is_frame_start(edge_cnt))
                    snaps[((edge_cnt / TD - PWR - 18) / 102) % 64] = data_in;
            end
            @(negedge CLOCK_50);
            e = rst_n ? edge_cnt : 0;
            b = rst_n ? exp_blon : 1'b0;
            check($sformatf("outputs@edge%0d", e),
                  {18'd0, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, frame_done, LCD_DATA},
                  {18'd0, model_out(e, b)});
            if (rst_n) begin
                if (LCD_EN === 1'b1 && !en_prev && rise_edge < 0) begin
                    rise_edge = e;
                    rise_data = LCD_DATA;
                end
                if (en_prev && LCD_EN === 1'b0) caps.push_back({LCD_RS, LCD_DATA});
                if (frame_done === 1'b1) fd_edges.push_back(e);
                en_prev = (LCD_EN === 1'b1);
            end
        end
    end

    task automatic wait_caps(input int n, input string name);
        int k = 0;
        while (caps.size() < n && k < 3000) begin
            @(negedge CLOCK_50);
            k++;
        end
        check(name, 32'(caps.size() >= n), 32'd1);
    endtask

    task automatic wait_rise(input string name);
        int k = 0;
        while (rise_edge < 0 && k < 200) begin
            @(negedge CLOCK_50);
            k++;
        end
        check({name, "_edge"}, 32'(rise_edge), 32'd12);
        check({name, "_data"}, 32'(rise_data), 32'h38);
    endtask

    initial begin
        logic [8:0] exp_q [$];
        string l1, l2;
        int k;
        l1 = "2024/05/17 12:30";
        l2 = "Friday          ";
        rst_n = 1'b1; bl_in = 1'b0; data_in = build(l1, l2);
        #2 rst_n = 1'b0;
        #1 check("reset_state", {LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, frame_done, LCD_DATA},
                 14'd0);
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b1;

        wait_rise("first_rise");
        wait_caps(20, "caps20");
        @(negedge CLOCK_50);
        bl_in = 1'b1;
        #1 check("blon_lag", LCD_BLON, 1'b0);
        @(negedge CLOCK_50);
        check("blon_rise", LCD_BLON, 1'b1);
        bl_in = 1'b0;
        @(negedge CLOCK_50);
        check("blon_fall", LCD_BLON, 1'b0);

        wait_caps(40, "caps40");
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, init_tab[i]});
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(l1[i])});
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(l2[i])});
        for (int i = 0; i < 40; i++)
            check($sformatf("frame_byte%0d", i), (i < caps.size()) ? caps[i] : 9'h1FF, exp_q[i]);

        k = 0;
        while (fd_edges.size() < 3 && k < 1500) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("fd_count", 32'(fd_edges.size() >= 3), 32'd1);
        if (fd_edges.size() >= 3) begin
            check("fd_first", 32'(fd_edges[0]), 32'd488);
            check("fd_period1", 32'(fd_edges[1] - fd_edges[0]), 32'd408);
            check("fd_period2", 32'(fd_edges[2] - fd_edges[1]), 32'd408);
        end

        // Reset mid-pulse, then snapshot coherence on the fresh run.
        k = 0;
        while (LCD_EN !== 1'b1 && k < 200) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("en_seen", LCD_EN, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_en", LCD_EN, 1'b0);
        check("rst_data", LCD_DATA, 8'h00);
        check("rst_rs", LCD_RS, 1'b0);
        check("rst_on", LCD_ON, 1'b0);
        data_in = {32{8'h41}};
        repeat (2) @(negedge CLOCK_50);
        rst_n = 1'b1;
        wait_rise("rerise");
        wait_caps(12, "caps12");
        data_in = {32{8'h42}};
        wait_caps(74, "caps74");
        for (int i = 6; i < 74; i++) begin
            logic [8:0] x;
            if (i == 6 || i == 40) x = 9'h080;
            else if (i == 23 || i == 57) x = 9'h0C0;
            else if (i < 40) x = 9'h141;
            else x = 9'h142;
            check($sformatf("coherent%0d", i), (i < caps.size()) ? caps[i] : 9'h1FF, x);
        end

        // Random data and backlight with one asynchronous reset; the model checks each cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLOCK_50);
            if ($urandom_range(0, 99) < 3)
                for (int j = 0; j < 8; j++) data_in[32*j +: 32] = $urandom;
            if ($urandom_range(0, 99) < 5) bl_in = ~bl_in;
            if (c == 1700) #($urandom_range(1, 3)) rst_n = 1'b0;
            if (c == 1703) rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
